// File: rtl/booth_multiplier.sv
// booth_multiplier: iterative signed WIDTH x WIDTH radix-4 Booth multiplier with start/ready handshake.
// Optional MULT_EARLY_EXIT_EN: zero operands bypass the Booth steps and finish in one cycle.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int PW = 2*WIDTH+3;
    localparam int CW = $clog2(WIDTH/2+1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH+1:0] mcand, mcand2, addend, sum;
    logic [PW-1:0] prod, prod_nxt;
    logic [2*WIDTH-1:0] full;
    logic [CW-1:0] cnt;
    logic last, zero_op;
    always_comb begin
        mcand2 = {mcand[WIDTH:0], 1'b0};
        addend = (prod[2:0] == 3'b011) ? mcand2 :
                 (prod[2:0] == 3'b100) ? -mcand2 :
                 (prod[2:0] == 3'b001 || prod[2:0] == 3'b010) ? mcand :
                 (prod[2:0] == 3'b101 || prod[2:0] == 3'b110) ? -mcand : '0;
        sum = prod[PW-1:WIDTH+1] + addend;
        prod_nxt = $signed({sum, prod[WIDTH:0]}) >>> 2;
        full = prod_nxt[2*WIDTH:1];
        last = cnt == CW'(WIDTH/2-1);
`ifdef MULT_EARLY_EXIT_EN
        zero_op = data_operandA == '0 || data_operandB == '0;
`else
        zero_op = 1'b0;
`endif
        state_nxt = ctrl_MULT ? (zero_op ? DONE : BUSY) :
                    state == BUSY ? (last ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            prod <= '0;
            cnt <= '0;
            data_result <= '0;
            data_exception <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ctrl_MULT) begin
                mcand <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                prod <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
                cnt <= '0;
                data_result <= '0;
                data_exception <= 1'b0;
            end else if (state == BUSY) begin
                prod <= prod_nxt;
                cnt <= cnt + CW'(1);
                if (last) begin
                    data_result <= full[WIDTH-1:0];
                    data_exception <= ~(&full[2*WIDTH-1:WIDTH-1] | ~|full[2*WIDTH-1:WIDTH-1]);
                end
            end
        end
    end
    assign data_resultRDY = state == DONE;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vectors for booth_multiplier with hand-computed products and latencies.
module tb_booth_multiplier;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic ctrl_MULT = 1'b0;
    logic [31:0] data_result;
    logic data_exception;
    logic data_resultRDY;
    int vectors = 0;
    int miscompares = 0;
`ifdef MULT_EARLY_EXIT_EN
    localparam int ZL = 0;
`else
    localparam int ZL = 16;
`endif
    booth_multiplier #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [31:0] a, input logic [31:0] b, input int hold);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = 1'b1;
        repeat (hold) @(negedge clock);
        ctrl_MULT = 1'b0;
        data_operandA = 32'hDEADBEEF;
        data_operandB = 32'h13579BDF;
    endtask
    task automatic wait_rdy(output int n);
        n = 0;
        while (!data_resultRDY && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask
    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input int lat, input int hold);
        int n;
        start(a, b, hold);
        wait_rdy(n);
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " rdy"}, 64'(data_resultRDY), 64'd1);
        check({tag, " result"}, 64'(data_result), 64'(er));
        check({tag, " exception"}, 64'(data_exception), 64'(ee));
        @(negedge clock);
        check({tag, " rdy drop"}, 64'(data_resultRDY), 64'd0);
        repeat (3) @(negedge clock);
        check({tag, " held"}, 64'(data_result), 64'(er));
    endtask
    initial begin
        int n;
        bit seen;
        repeat (2) @(negedge clock);
        check("reset result", 64'(data_result), 64'd0);
        check("reset exception", 64'(data_exception), 64'd0);
        check("reset rdy", 64'(data_resultRDY), 64'd0);
        reset = 1'b0;
        mul("3x5", 32'd3, 32'd5, 32'd15, 1'b0, 16, 1);
        mul("-7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0, 16, 1);
        mul("min x 1", 32'h80000000, 32'd1, 32'h80000000, 1'b0, 16, 1);
        mul("max x 2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b1, 16, 1);
        mul("min x -1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 16, 1);
        mul("-2^16 x 2^16", 32'hFFFF0000, 32'h00010000, 32'h00000000, 1'b1, 16, 1);
        mul("-1 x -1", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 16, 1);
        mul("0 x 12345", 32'd0, 32'd12345, 32'd0, 1'b0, ZL, 1);
        mul("12345 x 0", 32'd12345, 32'd0, 32'd0, 1'b0, ZL, 1);
        mul("held start 6x7", 32'd6, 32'd7, 32'd42, 1'b0, 16, 3);
        start(32'd3, 32'd5, 1);
        seen = 0;
        repeat (7) begin
            @(negedge clock);
            seen |= data_resultRDY;
        end
        data_operandA = 32'd4;
        data_operandB = 32'd4;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        data_operandA = 32'd77;
        wait_rdy(n);
        check("abort no rdy", 64'(seen), 64'd0);
        check("abort latency", 64'(n), 64'd16);
        check("abort result", 64'(data_result), 64'd16);
        start(32'd9, 32'd9, 1);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset result", 64'(data_result), 64'd0);
        check("async reset exception", 64'(data_exception), 64'd0);
        check("async reset rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clock);
            seen |= data_resultRDY;
        end
        check("no rdy after reset", 64'(seen), 64'd0);
        mul("9x9 after reset", 32'd9, 32'd9, 32'd81, 1'b0, 16, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
